// File: rtl/sad_sequencer.sv
// Block-match search sequencer for the SAD datapath: window fetch, two-column frame scan, strobes.
// Optional busy-cycle counter is built only when SAD_SEQ_CYCLE_COUNT_EN is defined.
module sad_sequencer #(
  parameter int ROW_STRIDE = 64,
  parameter int B_OFFSET   = 256,
  parameter int DIM_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [31:0]      frame_base,
  input  logic [31:0]      window_base,
  input  logic [DIM_W-1:0] num_rows,
  input  logic [DIM_W-1:0] num_cols,
  output logic             rd_en,
  output logic [31:0]      addr_a,
  output logic [31:0]      addr_b,
  output logic [31:0]      tag_addr,
  output logic             window_shift,
  output logic             frame_shift,
  output logic             min_in,
  output logic             min_clear,
  output logic             load_min,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      cycle_count
);

  localparam logic [31:0] STRIDE = 32'(ROW_STRIDE);
  localparam logic [31:0] BOFF   = 32'(B_OFFSET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_WIN,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      frame_base_q, frame_base_d;
  logic [31:0]      window_base_q, window_base_d;
  logic [DIM_W-1:0] rows_q, rows_d;
  logic [DIM_W-1:0] cols_q, cols_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             wshift_q, fshift_q, min_in_q;
  logic [31:0]      tag_q;

  logic             rd_en_c;
  logic [31:0]      addr_c;
  logic             start_acc;
  logic             dims_ok;
  logic             busy_c;

  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign dims_ok   = (num_rows >= DIM_W'(4)) && (num_cols != '0);
  assign busy_c    = (state_q == S_CLEAR) || (state_q == S_LOAD_WIN) ||
                     (state_q == S_SCAN)  || (state_q == S_DRAIN);

  // row_q doubles as the window-row index k while in LOAD_WIN.
  always_comb begin
    state_d       = state_q;
    frame_base_d  = frame_base_q;
    window_base_d = window_base_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    row_d         = row_q;
    col_d         = col_q;
    err_d         = err_q;
    done_d        = 1'b0;
    rd_en_c       = 1'b0;
    addr_c        = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          frame_base_d  = frame_base;
          window_base_d = window_base;
          rows_d        = num_rows;
          cols_d        = num_cols;
          row_d         = '0;
          col_d         = '0;
          if (dims_ok) begin
            err_d   = 1'b0;
            state_d = S_CLEAR;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_CLEAR: begin
        row_d   = '0;
        state_d = S_LOAD_WIN;
      end

      S_LOAD_WIN: begin
        rd_en_c = 1'b1;
        addr_c  = window_base_q + 32'(row_q) * STRIDE;
        if (row_q == DIM_W'(3)) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_SCAN;
        end else begin
          row_d = row_q + DIM_W'(1);
        end
      end

      S_SCAN: begin
        rd_en_c = 1'b1;
        addr_c  = frame_base_q + (32'(col_q) << 2) + 32'(row_q) * STRIDE;
        if (row_q == rows_q - DIM_W'(1)) begin
          row_d = '0;
          if (col_q == cols_q - DIM_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end else begin
          row_d = row_q + DIM_W'(1);
        end
      end

      S_DRAIN: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      frame_base_q  <= '0;
      window_base_q <= '0;
      rows_q        <= '0;
      cols_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      wshift_q      <= 1'b0;
      fshift_q      <= 1'b0;
      min_in_q      <= 1'b0;
      tag_q         <= '0;
    end else begin
      state_q       <= state_d;
      frame_base_q  <= frame_base_d;
      window_base_q <= window_base_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      row_q         <= row_d;
      col_q         <= col_d;
      err_q         <= err_d;
      done_q        <= done_d;
      // Strobes trail their read by the fixed one-cycle memory latency.
      wshift_q      <= (state_q == S_LOAD_WIN);
      fshift_q      <= (state_q == S_SCAN);
      min_in_q      <= (state_q == S_SCAN) && (row_q >= DIM_W'(3));
      tag_q         <= addr_c;
    end
  end

  assign rd_en        = rd_en_c;
  assign addr_a       = addr_c;
  assign addr_b       = rd_en_c ? (addr_c + BOFF) : '0;
  assign tag_addr     = tag_q;
  assign window_shift = wshift_q;
  assign frame_shift  = fshift_q;
  assign min_in       = min_in_q;
  assign min_clear    = (state_q == S_CLEAR);
  assign load_min     = (state_q == S_DONE);
  assign busy         = busy_c;
  assign done         = done_q;
  assign err          = err_q;

`ifdef SAD_SEQ_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if (busy_c) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_sad_sequencer.sv
// Scoreboard bench for sad_sequencer: expected strobe records are queued per run and a
// negedge monitor pops and compares them whenever a strobe or done appears.
module tb_sad_sequencer;

  localparam int W = 52;  // {rel_cycle[15:0], wshift, fshift, min_in, done, tag[31:0]}
`ifdef SAD_SEQ_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] frame_base = '0;
  logic [31:0] window_base = '0;
  logic [7:0]  num_rows = '0;
  logic [7:0]  num_cols = '0;
  logic        rd_en, window_shift, frame_shift, min_in, min_clear;
  logic        load_min, busy, done, err;
  logic [31:0] addr_a, addr_b, tag_addr, cycle_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_cnt = 0;
  int busy_cnt = 0;
  int mi_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs, exp_rec;

  sad_sequencer dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .frame_base(frame_base), .window_base(window_base),
    .num_rows(num_rows), .num_cols(num_cols),
    .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b), .tag_addr(tag_addr),
    .window_shift(window_shift), .frame_shift(frame_shift), .min_in(min_in),
    .min_clear(min_clear), .load_min(load_min), .busy(busy), .done(done),
    .err(err), .cycle_count(cycle_count)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mk(input int c, input logic ws, input logic fs,
                                      input logic mi, input logic dn, input logic [31:0] tag);
    return {16'(c), ws, fs, mi, dn, tag};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    int rel;
    rel = cyc - t0;
    if (window_shift || frame_shift || min_in || done) begin
      obs = mk(rel, window_shift, frame_shift, min_in, done, tag_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got=%h required=none", obs);
      end else begin
        exp_rec = exp_q.pop_front();
        if (obs !== exp_rec) begin
          errors++;
          $display("FAIL strobe_record got=%h required=%h", obs, exp_rec);
        end
      end
    end
    if (window_shift && frame_shift) begin
      checks++; errors++;
      $display("FAIL shift_overlap rel=%0d got=both required=exclusive", rel);
    end
    if (min_in) begin
      checks++;
      if (frame_shift !== 1'b1) begin
        errors++;
        $display("FAIL min_without_fshift rel=%0d got=%b required=1", rel, frame_shift);
      end
    end
    if (rd_en) begin
      checks++;
      if (addr_b - addr_a !== 32'd256) begin
        errors++;
        $display("FAIL addr_b_offset got=%h required=%h", addr_b, addr_a + 32'd256);
      end
    end
    if (min_clear) begin
      checks++;
      if (rel != 1) begin
        errors++;
        $display("FAIL min_clear_cycle got=%0d required=1", rel);
      end
    end
    if (rd_en === 1'b1) rd_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (min_in === 1'b1) mi_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_addr_a"}, addr_a, 0);
    chk({tag, "_addr_b"}, addr_b, 0);
    chk({tag, "_tag_addr"}, tag_addr, 0);
    chk({tag, "_strobes"}, {28'd0, window_shift, frame_shift, min_in, min_clear}, 0);
    chk({tag, "_load_min"}, 32'(load_min), 0);
    chk({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // Expected timeline: window strobes at 3..6, frame strobes at 7..6+N, done at 7+N.
  task automatic push_run(input int rows, input int cols, input logic [31:0] fb,
                          input logic [31:0] wb, input int cut);
    int n;
    logic [31:0] tag;
    n = rows * cols;
    for (int k = 0; k < 4; k++) begin
      tag = wb + 32'(k) * 32'd64;
      if (3 + k <= cut) exp_q.push_back(mk(3 + k, 1'b1, 1'b0, 1'b0, 1'b0, tag));
    end
    for (int i = 0; i < n; i++) begin
      tag = fb + 32'(i / rows) * 32'd4 + 32'(i % rows) * 32'd64;
      if (7 + i <= cut) exp_q.push_back(mk(7 + i, 1'b0, 1'b1, (i % rows) >= 3, 1'b0, tag));
    end
    if (7 + n <= cut) exp_q.push_back(mk(7 + n, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
  endtask

  task automatic run_start(input logic [7:0] r, input logic [7:0] c,
                           input logic [31:0] fb, input logic [31:0] wb);
    frame_base = fb; window_base = wb; num_rows = r; num_cols = c;
    start = 1'b1;
    t0 = cyc;
    rd_cnt = 0; busy_cnt = 0; mi_cnt = 0;
    tick();
    start = 1'b0;
    // Scramble inputs: the DUT must work from its latched copies.
    frame_base = $urandom; window_base = $urandom;
    num_rows = 8'($urandom_range(0, 255)); num_cols = 8'($urandom_range(0, 255));
  endtask

  task automatic run_legal(input int r, input int c, input logic [31:0] fb,
                           input logic [31:0] wb, input bit extra_starts);
    int n;
    n = r * c;
    push_run(r, c, fb, wb, 100000);
    run_start(8'(r), 8'(c), fb, wb);
    chk("clear_min_clear", 32'(min_clear), 1);
    chk("clear_err", 32'(err), 0);
    chk("clear_busy", 32'(busy), 1);
    wait_rel(2);
    chk("run_load_min", 32'(load_min), 0);
    chk("run_cycle_count", cycle_count, CC_EN ? 32'd1 : 32'd0);
    if (extra_starts) begin
      wait_rel(3); start = 1'b1; tick(); start = 1'b0;
      wait_rel(9); start = 1'b1; tick(); start = 1'b0;
    end
    wait_rel(7 + n);
    chk("done_load_min", 32'(load_min), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_cycle_count", cycle_count, CC_EN ? 32'(n + 6) : 32'd0);
    tick();
    chk("done_pulse_width", 32'(done), 0);
    chk("run_queue_empty", 32'(exp_q.size()), 0);
    chk("run_rd_cycles", 32'(rd_cnt), 32'(n + 4));
    chk("run_busy_cycles", 32'(busy_cnt), 32'(n + 6));
  endtask

  task automatic run_illegal(input int r, input int c);
    exp_q.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0));
    run_start(8'(r), 8'(c), 32'h0000_5000, 32'h0000_6000);
    chk("illegal_err", 32'(err), 1);
    chk("illegal_busy", 32'(busy), 0);
    tick();
    chk("illegal_err_sticky", 32'(err), 1);
    chk("illegal_done_width", 32'(done), 0);
    chk("illegal_cycle_count", cycle_count, 0);
    repeat (3) tick();
    chk("illegal_queue_empty", 32'(exp_q.size()), 0);
    chk("illegal_rd_cycles", 32'(rd_cnt), 0);
    chk("illegal_min_in", 32'(mi_cnt), 0);
  endtask

  task automatic run_reset_abort();
    push_run(8, 4, 32'h0000_4000, 32'h0000_3000, 8);
    run_start(8'd8, 8'd4, 32'h0000_4000, 32'h0000_3000);
    wait_rel(8);
    Reset = 1'b0;
    start = 1'b1;  // reset must win over a simultaneous start
    tick();
    start = 1'b0;
    chk_all_zero("abort");
    Reset = 1'b1;
    repeat (20) tick();
    chk("abort_queue_empty", 32'(exp_q.size()), 0);
    chk("abort_idle_busy", 32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    Reset = 1'b1;
    tick();

    run_legal(5, 2, 32'h0000_1000, 32'h0000_2000, 1'b0);
    run_illegal(3, 2);
    run_legal(4, 3, 32'hFFFF_FF80, 32'h0000_0100, 1'b0);
    run_illegal(4, 0);
    run_reset_abort();
    run_legal(5, 2, 32'h0000_1000, 32'h0000_2000, 1'b0);
    run_legal(5, 2, 32'h0000_1000, 32'h0000_2000, 1'b1);

    repeat (4) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_sequencer.md
# sad_sequencer

Controller that sequences the SAD datapath through one full block-match search. It fetches the 4-row reference window, then streams two frame columns in parallel (A and B, offset by `B_OFFSET` bytes) down the frame rows. Each shift, compare and min-update strobe is issued on the cycle its read data is valid. It sits between the memory-stage read ports and the SAD unit, and drives the SAD unit's `frame_shift`, `window_shift`, `min_in`, `load_min` and tag (`MEM_SAD_ALUResult`) inputs.

## Interface
- `ROW_STRIDE`, 64: byte distance between consecutive frame/window rows.
- `B_OFFSET`, 256: byte offset of the port-B column from the port-A column; matches the +256 tag rule in the SAD unit.
- `DIM_W`, 8: width of the row/column count inputs.

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a search; sampled only in IDLE or DONE.
- `frame_base`  in  32  byte address of frame row 0, column 0.
- `window_base`  in  32  byte address of window row 0.
- `num_rows`  in  DIM_W  frame rows per column; must be ≥ 4.
- `num_cols`  in  DIM_W  word columns to scan; must be ≥ 1.
- `rd_en`  out  1  read strobe for both ports.
- `addr_a`  out  32  port-A read address.
- `addr_b`  out  32  port-B read address; always `addr_a + B_OFFSET`.
- `tag_addr`  out  32  port-A address delayed one cycle; drives the SAD unit's `MEM_SAD_ALUResult`.
- `window_shift`  out  1  shift the window register.
- `frame_shift`  out  1  shift both frame registers.
- `min_in`  out  1  enable the min-register update.
- `min_clear`  out  1  one-cycle pulse that presets the min register to its maximum.
- `load_min`  out  1  select the min value, rather than the tag, on `SAD_value`.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  last start had illegal dimensions; sticky until the next start.
- `cycle_count`  out  32  busy-cycle counter (see Configuration).

## Operation
- States: IDLE, CLEAR, LOAD_WIN, SCAN, DRAIN, DONE.
- **IDLE/DONE**
  - On `start`, latch `frame_base`, `window_base`, `num_rows` and `num_cols`, then enter CLEAR.
  - If `num_rows < 4` or `num_cols == 0`: go straight to DONE, set `err=1`, pulse `done`, issue no reads and assert no `min_in`.
- **CLEAR**: `min_clear=1` for one cycle, then LOAD_WIN.
- **LOAD_WIN**
  - 4 reads at `window_base + k*ROW_STRIDE`, k = 0..3, one per cycle.
  - Each return is strobed with `window_shift=1`, `min_in=0`.
- **SCAN**
  - Reads at `frame_base + c*4 + r*ROW_STRIDE`; r is the inner loop (0..num_rows−1), c the outer loop (0..num_cols−1).
  - Each return is strobed with `frame_shift=1`.
  - `min_in=1` only for returns with r ≥ 3; rows 0..2 prime the shift registers.
  - Column change needs no bubble: rows 0..2 of the new column re-prime the registers.
- **DRAIN**: one cycle for the final return strobe, then DONE.
- **DONE**
  - `done` pulses for one cycle on entry.
  - `load_min=1` is held while in DONE so the SAD result is readable.
  - `load_min` drops when `start` is accepted.
- The `window_shift` and `frame_shift` strobes are never asserted together; `min_in` is never asserted without `frame_shift`.
- `start` while `busy` is ignored.
- Row/column counters are DIM_W bits wide and do not wrap; the address is computed in 32 bits and wraps modulo 2^32.

## Timing
- Read latency is a fixed 1 cycle: an address issued at cycle t produces its strobes and `tag_addr` at t+1.
- `start` sampled at cycle 0:
  - CLEAR at cycle 1.
  - Window reads at cycles 2–5.
  - With N = `num_rows*num_cols`, frame reads at cycles 6..5+N.
  - Last strobe at cycle 6+N (DRAIN).
  - `done` at cycle 7+N.
- `rd_en` is continuous from cycle 2 to 5+N.
- `busy` is 1 from CLEAR through DRAIN (N+6 cycles); it is 0 in IDLE and DONE.
- **Reset** (`Reset=0` at a clock edge):
  - Next cycle, all outputs are 0 and the state is IDLE.
  - This includes `load_min=0`, `err=0`, `cycle_count=0` and address outputs = 0.
  - Reset mid-search aborts with no `done`.
- Reset has priority over `start` in the same cycle.

## Configuration
- `SAD_SEQ_CYCLE_COUNT_EN`
  - Defined: `cycle_count` clears on accepted `start` and increments every cycle `busy=1`; it holds its value in DONE.
  - Undefined: `cycle_count` is tied to 0 and no counter logic is built.

## Test plan
- `num_rows=5`, `num_cols=2`, `frame_base=0x1000`, `window_base=0x2000`:
  - 4 `window_shift` strobes at cycles 3–6.
  - 10 `frame_shift` strobes at cycles 7–16.
  - `min_in` at cycles 10, 11, 15, 16 with `tag_addr` 0x10C0, 0x1100, 0x10C4, 0x1104.
  - `done` at cycle 17.
- Same run: `addr_b − addr_a == 256` on every read; `min_clear` only at cycle 1; `window_shift` and `frame_shift` never overlap.
- `num_rows=3` -> `done` one cycle after start, `err=1`, zero `rd_en`/`min_in`; a subsequent legal start clears `err`.
- `Reset=0` at cycle 8 of a `num_rows=8`, `num_cols=4` run -> next cycle all outputs 0, no `done`, a new `start` runs normally.
- `start` pulsed at cycles 3 and 9 during a run -> ignored; the timeline is identical to the single-start case.
- With `SAD_SEQ_CYCLE_COUNT_EN`, `num_rows=5`, `num_cols=2` -> `cycle_count=16` in DONE; without it -> `cycle_count=0` throughout.
